mux4_rr_arbiter: RTL



---
 rtl/mux4_rr_arbiter_pkg.sv | 11 +
 rtl/mux4_rr_arbiter_pick.sv | 23 ++
 rtl/mux4x1.sv | 10 +
 rtl/mux4_rr_arbiter.sv | 90 +++++++++
 4 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// rtl/mux4_rr_arbiter_pkg.sv - shared definitions for the 4-way round-robin output arbiter
package mux4_arb_defs;

  localparam int N_REQ = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mux4_rr_arbiter_pick.sv
// rtl/mux4_rr_arbiter_pick.sv - combinational rotating-priority pick over four requests
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] idx,
  output logic [3:0] onehot
);

  // Scan from the far end so the offset closest to ptr is the last write and wins.
  always_comb begin
    any = 1'b0;
    idx = ptr;
    for (int j = 3; j >= 0; j--) begin
      if (req[ptr + 2'(j)]) begin
        any = 1'b1;
        idx = ptr + 2'(j);
      end
    end
    onehot = any ? (4'b0001 << idx) : 4'b0000;
  end

endmodule

// File: rtl/mux4x1.sv
// rtl/mux4x1.sv - one-bit 4:1 datapath multiplexer
module mux4x1 (
  input  logic [3:0] d,
  input  logic [1:0] sel,
  output logic       y
);

  assign y = d[sel];

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin owner of the shared 4:1 one-bit output path
module mux4_rr_arbiter
  import mux4_arb_defs::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] data_in,
  output logic [N_REQ-1:0] grant,
  output logic [1:0]       sel,
  output logic             grant_valid,
  output logic             y
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  arb_state_t    state;
  logic [1:0]    ptr;
  logic [CW-1:0] cnt;

  logic       rel;
  logic [1:0] pick_ptr;
  logic       pick_any;
  logic [1:0] pick_idx;
  logic [3:0] pick_onehot;
  logic       mux_y;

  // While granted, the only pick that matters is the re-pick from just past the owner.
  assign pick_ptr = (state == ST_GRANT) ? (sel + 2'd1) : ptr;
  assign rel      = !req[sel] || (cnt == CW'(MAX_HOLD - 1));

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant       <= '0;
      sel         <= '0;
      grant_valid <= 1'b0;
      ptr         <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state       <= ST_GRANT;
            grant       <= pick_onehot;
            sel         <= pick_idx;
            grant_valid <= 1'b1;
            cnt         <= '0;
          end
        end
        ST_GRANT: begin
          if (rel) begin
            ptr <= sel + 2'd1;
            cnt <= '0;
            if (pick_any) begin
              grant <= pick_onehot;
              sel   <= pick_idx;
            end else begin
              state       <= ST_IDLE;
              grant       <= '0;
              grant_valid <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mux4x1 u_mux (
    .d   (data_in),
    .sel (sel),
    .y   (mux_y)
  );

  assign y = mux_y & grant_valid;

endmodule
